// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG raw-symbol bit packer.
package jpeg_pkg;

    localparam int         MAX_SIZE     = 11;
    localparam int         HDR_BITS     = 8;
    localparam int         BYTE_W       = 8;
    localparam int         SYM_BITS_MAX = HDR_BITS + MAX_SIZE;
    localparam logic [7:0] MARKER       = 8'hFF;
    localparam logic [7:0] STUFF        = 8'h00;

    // One run-length symbol as produced by the encoder core.
    typedef struct packed {
        logic [3:0]  rlen;
        logic [3:0]  size;
        logic [11:0] amp;
    } rle_sym_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAD   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } pack_state_t;

    // Number of amplitude bits actually packed; illegal sizes are clamped.
    function automatic logic [3:0] amp_bits(input logic [3:0] size);
        return (size > 4'(MAX_SIZE)) ? 4'(MAX_SIZE) : size;
    endfunction

endpackage

// File: rtl/jpeg_sync_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rd_data whenever
// empty is low. A write at full is accepted only when a read happens the
// same cycle.
module jpeg_sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr_reg];

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/jpeg_bit_packer.sv
// Serialises run-length symbols into a byte stream: 8-bit {rlen,size} header
// followed by the amplitude bits MSB-first, with 0xFF/0x00 stuffing and
// 1-padding on flush. Valid bits sit left-justified in the accumulator so the
// outgoing byte is always its top 8 bits.
module jpeg_bit_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int ACC_W      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        douten,
    input  logic [3:0]  size,
    input  logic [3:0]  rlen,
    input  logic [11:0] amp,
    input  logic        flush,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    input  logic        byte_ready,
    output logic        done,
    output logic        overflow,
    output logic        size_err
);

    import jpeg_pkg::*;

    localparam int CW        = $clog2(ACC_W + 1);
    // A pop is only allowed if a worst-case symbol still fits.
    localparam int POP_LIMIT = ACC_W - SYM_BITS_MAX;

    rle_sym_t                   in_sym;
    rle_sym_t                   head_sym;
    logic [$bits(rle_sym_t)-1:0] fifo_rd_data;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       pop;

    logic [ACC_W-1:0]           acc_reg, acc_next;
    logic [CW-1:0]              count_reg, count_next;
    logic                       stuff_pending_reg;
    logic                       flush_req_reg;
    logic                       overflow_reg;
    logic                       size_err_reg;
    logic                       done_reg;
    pack_state_t                state_reg;

    logic                       consume;
    logic                       data_consume;
    logic                       flush_active;
    logic                       idle;
    logic                       go_done;
    logic                       go_pad;
    logic [3:0]                 n_bits;
    logic [MAX_SIZE-1:0]        amp_just;
    logic [SYM_BITS_MAX-1:0]    sym_bits;
    logic [ACC_W-1:0]           sym_aligned;
    logic [CW-1:0]              sym_len;
    logic [ACC_W-1:0]           pad_mask;
    logic [ACC_W-1:0]           base_acc;
    logic [CW-1:0]              base_count;
    // Amplitude MSB can never be selected because size is clamped to 11.
    logic                       amp_msb_unused;

    assign in_sym = {rlen, size, amp};

    jpeg_sync_fifo #(
        .WIDTH ($bits(rle_sym_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (douten),
        .wr_data (in_sym),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty)
    );

    assign head_sym       = rle_sym_t'(fifo_rd_data);
    assign amp_msb_unused = head_sym.amp[11];

    // Output byte: a pending stuff byte always wins over accumulator data.
    assign byte_valid   = stuff_pending_reg | (count_reg >= CW'(BYTE_W));
    assign byte_data    = stuff_pending_reg ? STUFF : acc_reg[ACC_W-1 -: BYTE_W];
    assign consume      = byte_valid & byte_ready;
    assign data_consume = consume & ~stuff_pending_reg;

    assign done     = done_reg;
    assign overflow = overflow_reg;
    assign size_err = size_err_reg;

    // Nothing left upstream and no stuff byte owed: flush may pad or finish.
    // A symbol arriving this cycle holds off the decision so it is packed first.
    assign flush_active = flush_req_reg | flush;
    assign idle         = flush_active & fifo_empty & ~douten & ~stuff_pending_reg
                        & ((state_reg == ST_RUN) | (state_reg == ST_DRAIN));
    assign go_done      = idle & (count_reg == '0);
    assign go_pad       = idle & (count_reg != '0) & (count_reg < CW'(BYTE_W));

    assign pop = ~fifo_empty & (count_reg <= CW'(POP_LIMIT)) & (state_reg != ST_PAD);

    // Left-justify the selected amplitude bits; higher bits shift out.
    assign n_bits      = amp_bits(head_sym.size);
    assign amp_just    = head_sym.amp[MAX_SIZE-1:0] << (4'(MAX_SIZE) - n_bits);
    assign sym_bits    = {head_sym.rlen, head_sym.size, amp_just};
    assign sym_aligned = {sym_bits, {(ACC_W-SYM_BITS_MAX){1'b0}}};
    assign sym_len     = CW'(HDR_BITS) + CW'(n_bits);

    // Ones from just below the valid bits down to the end of the top byte.
    assign pad_mask = ({ACC_W{1'b1}} >> count_reg)
                    & {{BYTE_W{1'b1}}, {(ACC_W-BYTE_W){1'b0}}};

    // Accumulator update: drop the consumed byte, then append or pad.
    always_comb begin
        base_acc   = acc_reg;
        base_count = count_reg;
        if (data_consume) begin
            base_acc   = acc_reg << BYTE_W;
            base_count = count_reg - CW'(BYTE_W);
        end
        acc_next   = base_acc;
        count_next = base_count;
        if (state_reg == ST_PAD) begin
            acc_next   = acc_reg | pad_mask;
            count_next = CW'(BYTE_W);
        end else if (pop) begin
            acc_next   = base_acc | (sym_aligned >> base_count);
            count_next = base_count + sym_len;
        end
    end

    // Datapath registers and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg           <= '0;
            count_reg         <= '0;
            stuff_pending_reg <= 1'b0;
            overflow_reg      <= 1'b0;
            size_err_reg      <= 1'b0;
        end else begin
            acc_reg   <= acc_next;
            count_reg <= count_next;
            if (consume) begin
                stuff_pending_reg <= ~stuff_pending_reg
                                   & (acc_reg[ACC_W-1 -: BYTE_W] == MARKER);
            end
            if (douten & fifo_full & ~pop) begin
                overflow_reg <= 1'b1;
            end
            if (douten & (size > 4'(MAX_SIZE))) begin
                size_err_reg <= 1'b1;
            end
        end
    end

    // Flush sequencing: RUN -> PAD -> DRAIN -> DONE -> RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            flush_req_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_RUN, ST_DRAIN: begin
                    if (flush) begin
                        flush_req_reg <= 1'b1;
                    end
                    if (go_done) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else if (go_pad) begin
                        state_reg <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    state_reg <= ST_DRAIN;
                end
                ST_DONE: begin
                    flush_req_reg <= 1'b0;
                    state_reg     <= ST_RUN;
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: doc/jpeg_bit_packer.md
Name: jpeg_bit_packer

Overview:
Downstream of the JPEG encoder core (DCT/quant/zigzag/RLE). Consumes the encoder's per-coefficient run-length symbols (rlen, size, amp, douten strobe) and serialises them into a byte stream. Each symbol becomes an 8-bit raw header {rlen,size} followed by size amplitude bits, MSB-first. This is the raw-symbol mode used ahead of Huffman tables. JPEG 0xFF byte stuffing and 1-padding on flush are applied. Output is a valid/ready byte interface toward the NoC/host sink.

Parameters:
FIFO_DEPTH, 16, input symbol FIFO entries (power of 2, >=4)
ACC_W, 32, bit-accumulator width (fixed; >= 19 + 13)

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
douten  in  1  symbol strobe from encoder (no backpressure possible)
size  in  4  amplitude bit count, legal 0..11
rlen  in  4  zero run length
amp  in  12  amplitude; only size LSBs used
flush  in  1  single-cycle pulse: drain, pad, then signal done
byte_valid  out  1  output byte valid
byte_data  out  8  output byte
byte_ready  in  1  sink accepts byte when valid&ready
done  out  1  one-cycle pulse when flush completes
overflow  out  1  sticky: symbol dropped on full FIFO
size_err  out  1  sticky: size>11 received

Behaviour:
- Reset (synchronous, rst=1 at posedge): FIFO emptied, accumulator count=0, stuff_pending=0, flush_req=0. Outputs: byte_valid=0, byte_data=0, done=0, overflow=0, size_err=0. Applies mid-stream; all in-flight bits are discarded.
- Push: douten=1 writes {rlen,size,amp} into the FIFO. If the FIFO is full and no pop occurs that cycle, the symbol is dropped and overflow is set. Push and pop in the same cycle at full is accepted.
- size>11: size_err is set and the symbol is packed with 11 bits.
- Pop: occurs when the FIFO is non-empty and acc count <= 13. Appends header(8) plus n amplitude bits to the accumulator LSB side in one cycle. New count = count + 8 + n - (8 if a byte is consumed this cycle).
- Emit: byte_valid=1 when stuff_pending=1, or when count >= 8.
  - With stuff_pending=1, byte_data=8'h00 and this byte takes priority over any other.
  - Otherwise byte_data is the top 8 bits of the accumulator.
- Handshake: a byte is consumed on byte_valid & byte_ready.
  - byte_data and byte_valid stay stable while ready=0.
  - Consuming 0xFF sets stuff_pending; consuming the stuffed 0x00 clears it.
- Latency: douten at cycle t, pop at t+1, byte_valid high at t+2 when count >= 8 and byte_ready has been high.
- Flush: flush sets flush_req; a flush arriving while flush_req is already set is ignored.
  - When the FIFO is empty, 0 < count < 8 and no stuff is pending, the accumulator is padded with 1s to 8 bits (one cycle). That byte is then emitted, with stuffing if it is 0xFF.
  - done pulses for one cycle the cycle after FIFO empty, count=0 and stuff_pending=0 all hold; flush_req then clears.
  - flush with nothing pending pulses done 1 cycle later.
- douten during flush_req: the symbol is accepted and packed before padding.
- FSM states:
  - RUN: normal pop/emit; go to PAD when the flush conditions hold.
  - PAD: pad with 1s, then return to DRAIN.
  - DRAIN: emit until empty; when empty and count=0, go to DONE.
  - DONE: one cycle, assert done, return to RUN.

Decomposition:
- jpeg_pkg holds:
  - typedef rle_sym_t {rlen[3:0], size[3:0], amp[11:0]}
  - constants MAX_SIZE=11, HDR_BITS=8, MARKER=8'hFF, STUFF=8'h00
  - packer state enum
- Sub-module jpeg_sync_fifo: parameterised width/depth, synchronous rst, full/empty, registered write, show-ahead read.

Test Plan:
1. Strobe rlen=0,size=0 (EOB), then flush -> byte 0x00, then done pulse; no padding byte.
2. Strobe rlen=2,size=3,amp=0x005, then flush -> bytes 0x23, 0xBF (101 + 11111 pad), then done.
3. Strobe rlen=0,size=8,amp=0x0FF, then flush -> bytes 0x08, 0xFF, 0x00 (stuffed); done only after 0x00 is consumed.
4. byte_ready=0 for 40 cycles; 20 back-to-back strobes size=11, FIFO_DEPTH=16 -> symbols 1-17 retained, symbol 18 onward dropped, overflow=1. After ready=1, exactly 17*19 bits are emitted (plus any 0x00 stuffing), and byte_data stays stable while stalled.
5. Strobe size=13,rlen=1,amp=0xFFF -> size_err=1 and header 0x1D. The 11 amplitude bits 0x7FF produce stuffed 0xFF, 0x00; flush pads the remaining bits.
6. rst asserted mid-emission with FIFO non-empty -> next cycle byte_valid=0, overflow=0, size_err=0; a subsequent single symbol of test 2 reproduces 0x23, 0xBF exactly.
